// File: rtl/fetch_mem_if.sv
// Bundles the fetch/data request buses and the single-port RAM handshake.
// The arbiter takes the slave view; the requester plus RAM side takes the master view.
interface fetch_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              ihit;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [DATA_W-1:0] dload;
  logic              dhit;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ramACK;
  logic              err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramACK,
    output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramACK,
    input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/fetch_mem_arbiter.sv
// Serialises instruction fetches and data accesses onto one REQ/ACK RAM port,
// data first, with a one-cycle response state and an optional ACK timeout.
module fetch_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic       CLK,
  input  logic       RST,
  fetch_mem_if.slave bus
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LIMIT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, IACC, DACC, RESP} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] store_q;
  logic [DATA_W-1:0] iload_q;
  logic [DATA_W-1:0] dload_q;
  logic              wr_q;
  logic              data_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt;
  logic              start;
  logic              start_data;
  logic              capture;
  logic              abort;
  logic              in_acc;
  logic              timeout_hit;

  assign in_acc      = (state == IACC) || (state == DACC);
  // Abort on the edge that would take the count to TIMEOUT; an ACK on that edge still wins.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(LIMIT));

  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.err      = err_q;

  // NOTE: state and registers update with <= so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
    state_n    = state;
    start      = 1'b0;
    start_data = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    bus.ramREN = 1'b0;
    bus.ramWEN = 1'b0;
    bus.ihit   = 1'b0;
    bus.dhit   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.dREN || bus.dWEN) begin
          state_n    = DACC;
          start      = 1'b1;
          start_data = 1'b1;
        end else if (bus.iREN) begin
          state_n = IACC;
          start   = 1'b1;
        end
      end
      IACC, DACC: begin
        bus.ramWEN = (state == DACC) && wr_q;
        bus.ramREN = !bus.ramWEN;
        if (bus.ramACK) begin
          state_n = RESP;
          capture = 1'b1;
        end else if (timeout_hit) begin
          state_n = IDLE;
          abort   = 1'b1;
        end
      end
      RESP: begin
        // Holding here one cycle lets the requester move its address before IDLE samples it.
        bus.ihit = !data_q;
        bus.dhit = data_q;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q  <= '0;
      store_q <= '0;
      iload_q <= '0;
      dload_q <= '0;
      wr_q    <= 1'b0;
      data_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      err_q <= abort;
      if (start) begin
        addr_q  <= (start_data ? bus.daddr : bus.iaddr) & ~ADDR_W'(3);
        store_q <= bus.dstore;
        wr_q    <= start_data && bus.dWEN;
        data_q  <= start_data;
        cnt     <= '0;
      end else if (in_acc && !bus.ramACK) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (capture) begin
        if (!data_q)    iload_q <= bus.ramload;
        else if (!wr_q) dload_q <= bus.ramload;
      end
    end
  end
endmodule
